rvga_mem_arbiter: RTL and testbench

- Shares the single cacheline-wide memory port between the instruction-fetch requester (port I, read-only) and the load/store requester (port D, read/write).
- Accepts one 128-bit cacheline transaction at a time and drives it to memory with a valid/ready handshake.
- Routes the memory response back to the requester that owns the transaction.
- Round-robin arbitration on contention. Sits between the fetch/LSU front ends and the memory model/controller.

---
 rtl/rvga_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_rvga_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvga_mem_arbiter.sv
// Round-robin arbiter sharing one cacheline-wide memory port between the
// instruction-fetch (read-only) and load/store requesters, one transaction in flight.
module rvga_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  i_req_v_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_ready_o,
  output logic                  i_resp_v_o,
  output logic [LINE_WIDTH-1:0] i_resp_data_o,
  input  logic                  d_req_v_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [LINE_WIDTH-1:0] d_wdata_i,
  output logic                  d_ready_o,
  output logic                  d_resp_v_o,
  output logic [LINE_WIDTH-1:0] d_resp_data_o,
  output logic                  mem_req_v_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [LINE_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_resp_v_i,
  input  logic [LINE_WIDTH-1:0] mem_rdata_i
);

  localparam logic [ADDR_WIDTH-1:0] AddrMask = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
  localparam logic OwnI = 1'b0;
  localparam logic OwnD = 1'b1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  grant_i, grant_d;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    i_ready_o    = 1'b0;
    d_ready_o    = 1'b0;
    mem_req_v_o  = 1'b0;
    i_resp_v_o   = 1'b0;
    d_resp_v_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On a tie the port that did not win last contention gets the slot.
        if (!reset_i) begin
          if (i_req_v_i && (!d_req_v_i || last_grant_q == OwnD)) begin
            grant_i = 1'b1;
          end else if (d_req_v_i) begin
            grant_d = 1'b1;
          end
        end
        if (grant_i) begin
          i_ready_o = 1'b1;
          owner_d   = OwnI;
          we_d      = 1'b0;
          addr_d    = i_addr_i & AddrMask;
          state_d   = StIssue;
          if (d_req_v_i) begin
            last_grant_d = OwnI;
          end
        end else if (grant_d) begin
          d_ready_o = 1'b1;
          owner_d   = OwnD;
          we_d      = d_we_i;
          addr_d    = d_addr_i & AddrMask;
          wdata_d   = d_wdata_i;
          state_d   = StIssue;
          if (i_req_v_i) begin
            last_grant_d = OwnD;
          end
        end
      end
      StIssue: begin
        mem_req_v_o = 1'b1;
        if (mem_ready_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_resp_v_i) begin
          if (owner_q == OwnI) begin
            i_rdata_d = mem_rdata_i;
          end else begin
            d_rdata_d = mem_rdata_i;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        i_resp_v_o = (owner_q == OwnI);
        d_resp_v_o = (owner_q == OwnD);
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      owner_q      <= OwnI;
      last_grant_q <= OwnD;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_we_o      = (state_q == StIssue) && we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign i_resp_data_o = i_rdata_q;
  assign d_resp_data_o = d_rdata_q;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Self-checking bench for rvga_mem_arbiter: vector table, scoreboard of expected
// responses, and hand-written sequences for contention, backpressure and reset.
module tb_rvga_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          i_req_v_i, d_req_v_i, d_we_i;
  logic [AW-1:0] i_addr_i, d_addr_i;
  logic [LW-1:0] d_wdata_i;
  logic          i_ready_o, i_resp_v_o, d_ready_o, d_resp_v_o;
  logic [LW-1:0] i_resp_data_o, d_resp_data_o;
  logic          mem_req_v_o, mem_we_o, mem_ready_i, mem_resp_v_i;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_wdata_o, mem_rdata_i;

  rvga_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .i_req_v_i     (i_req_v_i),
    .i_addr_i      (i_addr_i),
    .i_ready_o     (i_ready_o),
    .i_resp_v_o    (i_resp_v_o),
    .i_resp_data_o (i_resp_data_o),
    .d_req_v_i     (d_req_v_i),
    .d_we_i        (d_we_i),
    .d_addr_i      (d_addr_i),
    .d_wdata_i     (d_wdata_i),
    .d_ready_o     (d_ready_o),
    .d_resp_v_o    (d_resp_v_o),
    .d_resp_data_o (d_resp_data_o),
    .mem_req_v_o   (mem_req_v_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_ready_i   (mem_ready_i),
    .mem_resp_v_i  (mem_resp_v_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    logic [AW-1:0] exp_addr;
    bit            exp_we;
  } vec_t;

  typedef struct {
    bit            port;
    bit            chk_data;
    logic [LW-1:0] data;
  } sb_t;

  int   checks = 0;
  int   errors = 0;
  sb_t  sb_q[$];
  sb_t  mon_e;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (i_ready_o && d_ready_o) begin
      checks++;
      errors++;
      $display("FAIL both_ready: got 11 expected at most one");
    end
    if (i_resp_v_o || d_resp_v_o) begin
      checks++;
      if (i_resp_v_o && d_resp_v_o) begin
        errors++;
        $display("FAIL resp_both: got both resp_v expected one");
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got resp_v i=%0b d=%0b expected none", i_resp_v_o,
                 d_resp_v_o);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.port != d_resp_v_o) begin
          errors++;
          $display("FAIL resp_port: got %0b expected %0b", d_resp_v_o, mon_e.port);
        end else if (mon_e.chk_data &&
                     ((mon_e.port ? d_resp_data_o : i_resp_data_o) !== mon_e.data)) begin
          errors++;
          $display("FAIL resp_data: got %0h expected %0h",
                   mon_e.port ? d_resp_data_o : i_resp_data_o, mon_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic wait_grant(output bit port, output int waited, output bit ok);
    ok = 1'b0;
    port = 1'b0;
    waited = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (i_ready_o || d_ready_o) begin
        port = d_ready_o;
        waited = c;
        ok = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL grant_timeout: got no ready expected ready within 20 cycles");
  endtask

  // Entered one step after the accepting edge (ISSUE); returns one step into IDLE.
  task automatic issue_and_complete(input bit port, input bit exp_we, input logic [AW-1:0] exp_addr,
                                    input logic [LW-1:0] exp_wdata, input logic [LW-1:0] rdata,
                                    input int bp, input bit spur);
    for (int k = 0; k < bp; k++) begin
      mem_ready_i = 1'b0;
      mem_resp_v_i = spur;
      @(negedge clk);
      chk("bp_req_v", mem_req_v_o, 1'b1);
      chk("bp_addr", mem_addr_o, exp_addr);
      chk("bp_we", mem_we_o, exp_we);
      if (exp_we) chk("bp_wdata", mem_wdata_o, exp_wdata);
      @(posedge clk);
      #1;
    end
    mem_resp_v_i = 1'b0;
    mem_ready_i = 1'b1;
    @(negedge clk);
    chk("issue_req_v", mem_req_v_o, 1'b1);
    chk("issue_addr", mem_addr_o, exp_addr);
    chk("issue_we", mem_we_o, exp_we);
    chk("issue_no_ready", {i_ready_o, d_ready_o}, 2'b00);
    if (exp_we) chk("issue_wdata", mem_wdata_o, exp_wdata);
    @(posedge clk);
    #1;
    mem_ready_i = 1'b0;
    @(negedge clk);
    chk("wait_req_v", mem_req_v_o, 1'b0);
    mem_resp_v_i = 1'b1;
    mem_rdata_i = rdata;
    sb_q.push_back('{port: port, chk_data: !exp_we, data: rdata});
    @(posedge clk);
    #1;
    mem_resp_v_i = 1'b0;
    mem_rdata_i = {4{32'hBAD0_BAD0}};
    @(negedge clk);
    chk("resp_pulse", port ? d_resp_v_o : i_resp_v_o, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int bp, input bit spur);
    bit p, ok;
    int w;
    i_req_v_i = !v.is_d;
    d_req_v_i = v.is_d;
    d_we_i = v.we;
    i_addr_i = v.addr;
    d_addr_i = v.addr;
    d_wdata_i = v.wdata;
    wait_grant(p, w, ok);
    i_req_v_i = 1'b0;
    d_req_v_i = 1'b0;
    if (ok) begin
      chk("grant_port", p, v.is_d);
      chk("grant_latency", w, 0);
      issue_and_complete(v.is_d, v.exp_we, v.exp_addr, v.wdata, v.rdata, bp, spur);
    end
  endtask

  initial begin
    bit p, ok;
    int w;
    logic [AW-1:0] exp_a;

    vecs[0] = '{0, 0, 32'h0000_1234, '0, {16{8'hA5}}, 32'h0000_1230, 0};
    vecs[1] = '{1, 1, 32'h0000_0040, {4{32'hDEAD_BEEF}}, {4{32'h5555_AAAA}}, 32'h0000_0040, 1};
    vecs[2] = '{1, 0, 32'h0000_ABCF, {4{32'h0F0F_0F0F}}, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                32'h0000_ABC0, 0};
    vecs[3] = '{0, 1, 32'hFFFF_FFFF, '0, {8{16'hC3C3}}, 32'hFFFF_FFF0, 0};
    vecs[4] = '{1, 1, 32'h8000_0007, 128'h1, '0, 32'h8000_0000, 1};

    reset_i = 1'b1;
    i_req_v_i = 1'b0;
    d_req_v_i = 1'b0;
    d_we_i = 1'b0;
    i_addr_i = '0;
    d_addr_i = '0;
    d_wdata_i = '0;
    mem_ready_i = 1'b0;
    mem_resp_v_i = 1'b0;
    mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_flags", {i_ready_o, d_ready_o, i_resp_v_o, d_resp_v_o, mem_req_v_o, mem_we_o}, '0);
    chk("rst_mem_addr", mem_addr_o, '0);
    chk("rst_mem_wdata", mem_wdata_o, '0);
    chk("rst_i_data", i_resp_data_o, '0);
    chk("rst_d_data", d_resp_data_o, '0);
    @(posedge clk);
    #1;

    // Continuous contention: I wins first after reset, then strict alternation.
    i_addr_i = 32'h0000_0104;
    d_addr_i = 32'h0000_0208;
    d_we_i = 1'b0;
    i_req_v_i = 1'b1;
    d_req_v_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(p, w, ok);
      if (k == 3) begin
        i_req_v_i = 1'b0;
        d_req_v_i = 1'b0;
      end
      if (!ok) break;
      chk("rr_order", p, k % 2);
      exp_a = p ? 32'h0000_0200 : 32'h0000_0100;
      issue_and_complete(p, 1'b0, exp_a, '0, {4{32'h1111_0000 + 32'(k)}}, 0, 1'b0);
    end
    i_req_v_i = 1'b0;
    d_req_v_i = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], 0, 1'b0);

    // Backpressure on a write, then spurious responses while stalled in ISSUE.
    run_vec(vecs[1], 5, 1'b0);
    run_vec(vecs[2], 3, 1'b1);

    // Spurious memory handshakes while IDLE.
    mem_resp_v_i = 1'b1;
    mem_ready_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_spur_resp", {i_resp_v_o, d_resp_v_o}, 2'b00);
      chk("idle_spur_req", mem_req_v_o, 1'b0);
      @(posedge clk);
      #1;
    end
    mem_resp_v_i = 1'b0;
    mem_ready_i = 1'b0;
    @(negedge clk);
    chk("idle_spur_after", {i_resp_v_o, d_resp_v_o, mem_req_v_o}, 3'b000);
    @(posedge clk);
    #1;

    // Reset while waiting for the memory response.
    i_addr_i = 32'h0000_0500;
    i_req_v_i = 1'b1;
    wait_grant(p, w, ok);
    i_req_v_i = 1'b0;
    mem_ready_i = 1'b1;
    @(posedge clk);
    #1;
    mem_ready_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("wrst_flags", {i_ready_o, d_ready_o, i_resp_v_o, d_resp_v_o, mem_req_v_o, mem_we_o}, '0);
    chk("wrst_mem_addr", mem_addr_o, '0);
    chk("wrst_i_data", i_resp_data_o, '0);
    mem_resp_v_i = 1'b1;
    mem_rdata_i = {4{32'h7777_7777}};
    @(posedge clk);
    #1;
    mem_resp_v_i = 1'b0;
    @(negedge clk);
    chk("wrst_late_resp", {i_resp_v_o, d_resp_v_o, mem_req_v_o}, 3'b000);
    @(posedge clk);
    #1;
    run_vec(vecs[0], 0, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
